// File: rtl/seq_divider_core.sv
// seq_divider_core: multi-cycle restoring divider, one quotient bit per cycle, valid/ready in and out.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitudes through the unsigned core).
module seq_divider_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] a, b, rem, q, rem_next, q_next, q_fin, r_fin;
  logic [WIDTH:0] partial, diff;
  logic [CW-1:0] cnt;
  logic ge, dz, last;
`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  // A zero divisor still spends one CALC cycle so its result lands one edge after capture.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_valid ? CALC : IDLE;
      CALC:    state_next = last ? DONE : CALC;
      DONE:    state_next = result_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    start_ready  = state == IDLE;
    result_valid = state == DONE;
  end
  always_comb begin
    last     = dz || cnt == '0;
    partial  = {rem, a[WIDTH-1]};
    diff     = partial - {1'b0, b};
    ge       = partial >= {1'b0, b};
    rem_next = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ge};
`ifdef DIVIDER_SIGNED_EN
    q_fin = dz ? '1 : neg_q ? -q_next : q_next;
    r_fin = neg_r ? -(dz ? a : rem_next) : (dz ? a : rem_next);
`else
    q_fin = dz ? '1 : q_next;
    r_fin = dz ? a : rem_next;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && start_valid) begin
        dz  <= divisor == '0;
        cnt <= CW'(WIDTH - 1);
        rem <= '0;
        q   <= '0;
`ifdef DIVIDER_SIGNED_EN
        a     <= dividend[WIDTH-1] ? -dividend : dividend;
        b     <= divisor[WIDTH-1] ? -divisor : divisor;
        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r <= dividend[WIDTH-1];
`else
        a <= dividend;
        b <= divisor;
`endif
      end
      if (state == CALC) begin
        a   <= a << 1;
        rem <= rem_next;
        q   <= q_next;
        cnt <= cnt - 1'b1;
        if (last) begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= dz;
        end
      end
    end
endmodule

// File: doc/seq_divider_core.md
# seq_divider_core

Parametrised multi-cycle restoring divider for the KPN arithmetic modules, and the next generation of the 16-bit divider node. It accepts dividend/divisor pairs over a valid/ready handshake and produces one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. Optional two's-complement mode is selected at compile time.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high; clock clk
- start_valid  in  1  operand pair present
- start_ready  out  1  block can accept operands (high only in IDLE)
- dividend  in  WIDTH  dividend, sampled on start handshake
- divisor  in  WIDTH  divisor, sampled on start handshake
- result_valid  out  1  quotient/remainder/div_by_zero valid
- result_ready  in  1  consumer takes result
- quotient  out  WIDTH  quotient
- remainder  out  WIDTH  remainder
- div_by_zero  out  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start_ready=1. On start_valid=1, capture the operands.
  - divisor≠0: load counter=WIDTH-1, clear partial remainder and quotient shift register, go to CALC.
  - divisor=0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
- CALC, each cycle:
  - partial = {rem, next dividend bit, MSB first}, held in WIDTH+1 bits so the compare cannot overflow.
  - If partial ≥ divisor: rem = partial − divisor and shift 1 into the quotient. Otherwise rem = partial and shift 0 into the quotient.
  - counter decrements; when counter=0 is processed, go to DONE.
- On the transition into DONE, register quotient, remainder and div_by_zero (0 on the normal path). Set result_valid=1.
- DONE: hold all outputs stable until result_valid && result_ready, then go to IDLE. result_valid drops the same edge.
- quotient, remainder and div_by_zero keep their last value after the handshake. They change only on the next entry to DONE.
- start_valid outside IDLE is ignored; operands are not sampled.
- Reset is allowed in any state, including mid-CALC. The operation is aborted and nothing is reported.
- Reset values: state=IDLE, start_ready=1, result_valid=0, quotient=0, remainder=0, div_by_zero=0.

## Timing
- Start handshake at edge E. result_valid is high in the cycle after edge E+WIDTH (normal case) or after edge E+1 (divide by zero).
- If result_ready is already high when result_valid rises, the result is consumed in that cycle. start_ready is high in the next cycle.
- Minimum issue interval: WIDTH+2 cycles (normal), 3 cycles (divide by zero).
- Outputs are registered; there is no combinational path from inputs to outputs.
- result_ready low in DONE stalls indefinitely with no loss of result.

## Configuration
- DIVIDER_SIGNED_EN defined: operands are two's complement.
  - On capture, store the operand magnitudes and the sign bits; the unsigned core runs unchanged.
  - On entry to DONE, negate the quotient if the signs differ. The remainder takes the dividend's sign (truncation toward zero).
  - Latency is unchanged.
  - Most-negative ÷ −1: quotient wraps to the most-negative value, remainder 0, div_by_zero=0.
  - Divide by zero behaves as in unsigned mode: quotient all ones (−1), remainder = dividend, div_by_zero=1.
- DIVIDER_SIGNED_EN undefined: purely unsigned; no sign logic is synthesised.

## Test plan
- Unsigned, WIDTH=16: 100 ÷ 7 handshake at edge E -> result_valid after edge E+16, quotient=14, remainder=2, div_by_zero=0. Also 0xFFFF ÷ 1 -> 0xFFFF rem 0 and 5 ÷ 9 -> 0 rem 5.
- Divide by zero: 0x1234 ÷ 0 -> after 1 cycle quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Backpressure: result_ready low for 5 cycles in DONE -> outputs stable, start_ready=0, start_valid pulses ignored. Raise result_ready -> IDLE next cycle; the next operation then runs correctly.
- Reset mid-CALC at iteration 8 -> next cycle all outputs at reset values and start_ready=1. A following 50 ÷ 5 -> 10 rem 0.
- Back-to-back: start_valid held high with three queued pairs and result_ready held high -> three correct results, issue interval WIDTH+2.
- DIVIDER_SIGNED_EN: −100 ÷ 7 -> quotient 0xFFF2 (−14), remainder 0xFFFE (−2). 100 ÷ −7 -> −14 rem 2. 0x8000 ÷ 0xFFFF -> 0x8000 rem 0.
